pp_pattern_sequencer: RTL and testbench

Sequencer that drives stored (x,y) input patterns into the team's 4-state x/y pattern FSM (states SA/SB/SC/SD, Moore output q). It resets the FSM, plays a loaded pattern one symbol per cycle, and counts how many sampled cycles had q high. It sits between the bench/host register interface and one FSM instance, and owns that FSM's reset and x/y inputs.

---
 rtl/pp_pattern_sequencer.sv | 146 ++++++++++++++
 tb/tb_pp_pattern_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pp_pattern_sequencer.sv
// Pattern sequencer: buffers {x,y} symbols, resets a downstream x/y FSM, plays the
// pattern one symbol per cycle and counts sampled cycles where the FSM output q is high.
module pp_pattern_sequencer #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Load,
    input  logic [1:0]    LoadData,
    input  logic          Clear,
    input  logic          Start,
    input  logic          q_in,
    output logic          FsmRst,
    output logic          x,
    output logic          y,
    output logic          Busy,
    output logic          Done,
    output logic          Full,
    output logic [CW-1:0] HighCount
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRST,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_index;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_buf [DEPTH];
    logic               r_fsm_rst;
    logic               r_x;
    logic               r_y;
    logic               r_busy;
    logic               r_done;
    logic               r_full;
    logic [CW-1:0]      r_high;

    state_t             w_next_state;
    logic [IDX_W-1:0]   w_next_index;
    logic [CNT_W-1:0]   w_next_count;
    logic               w_start_ok;
    logic               w_wr_en;
    logic               w_last;
    logic               w_sample;
    logic [1:0]         w_sym;

    assign w_last   = (CNT_W'(r_index) == (r_count - CNT_W'(1)));
    assign w_sample = (r_state == S_RUN) || (r_state == S_DRAIN);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_index = r_index;
        w_next_count = r_count;
        w_start_ok   = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // An accepted Start swallows any Load/Clear issued in the same cycle.
                if (Start && (r_count != '0)) begin
                    w_start_ok   = 1'b1;
                    w_next_state = S_FRST;
                end else if (Clear) begin
                    w_next_count = '0;
                end else if (Load && (r_count < CNT_W'(DEPTH))) begin
                    w_wr_en      = 1'b1;
                    w_next_count = r_count + CNT_W'(1);
                end
            end
            S_FRST: begin
                w_next_state = S_RUN;
                w_next_index = '0;
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DRAIN;
                end else begin
                    w_next_index = r_index + IDX_W'(1);
                end
            end
            S_DRAIN: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        w_sym = r_buf[w_next_index];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_index   <= '0;
            r_count   <= '0;
            r_fsm_rst <= 1'b0;
            r_x       <= 1'b0;
            r_y       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_full    <= 1'b0;
            r_high    <= '0;
        end else begin
            r_state   <= w_next_state;
            r_index   <= w_next_index;
            r_count   <= w_next_count;
            // Outputs are decoded from the next state so they are registered yet aligned with it.
            r_fsm_rst <= (w_next_state == S_FRST);
            r_busy    <= (w_next_state == S_FRST) || (w_next_state == S_RUN) ||
                         (w_next_state == S_DRAIN);
            r_done    <= (w_next_state == S_DONE);
            r_full    <= (w_next_count == CNT_W'(DEPTH));
            {r_x, r_y} <= (w_next_state == S_RUN) ? w_sym : 2'b00;
            if (w_start_ok) begin
                r_high <= '0;
            end else if (w_sample && q_in && (r_high != '1)) begin
                r_high <= r_high + CW'(1);
            end
        end
    end

    // NOTE: the pattern storage has no reset; entries beyond the count are never read,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_buf[r_count[IDX_W-1:0]] <= LoadData;
        end
    end

    assign FsmRst    = r_fsm_rst;
    assign x         = r_x;
    assign y         = r_y;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Full      = r_full;
    assign HighCount = r_high;

endmodule

// File: tb/tb_pp_pattern_sequencer.sv
// Self-checking bench for pp_pattern_sequencer: directed steps with random patterns and
// random q_in, compared against a cycle-indexed model of the run timeline.
module tb_pp_pattern_sequencer;

    localparam int DEPTH = 8;
    localparam int CW    = 3;
    localparam int HMAX  = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Load = 1'b0;
    logic [1:0]    LoadData = 2'b00;
    logic          Clear = 1'b0;
    logic          Start = 1'b0;
    logic          q_in = 1'b0;
    logic          FsmRst;
    logic          x;
    logic          y;
    logic          Busy;
    logic          Done;
    logic          Full;
    logic [CW-1:0] HighCount;

    pp_pattern_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Load      (Load),
        .LoadData  (LoadData),
        .Clear     (Clear),
        .Start     (Start),
        .q_in      (q_in),
        .FsmRst    (FsmRst),
        .x         (x),
        .y         (y),
        .Busy      (Busy),
        .Done      (Done),
        .Full      (Full),
        .HighCount (HighCount)
    );

    always #5 Clk = ~Clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [1:0] model_buf [DEPTH];
    int         model_count = 0;
    int         model_high = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Vector order: {FsmRst, Busy, Done, x, y}
    function automatic logic [4:0] outs();
        return {FsmRst, Busy, Done, x, y};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_outs"}, 32'(outs()), 32'd0);
        check({tag, "_high"}, 32'(HighCount), 32'(model_high));
        check({tag, "_full"}, 32'(Full), 32'(model_count == DEPTH));
    endtask

    task automatic load_sym(input logic [1:0] sym);
        Load = 1'b1;
        LoadData = sym;
        @(negedge Clk);
        Load = 1'b0;
        if (model_count < DEPTH) begin
            model_buf[model_count] = sym;
            model_count++;
        end
    endtask

    task automatic clear_buf();
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        model_count = 0;
    endtask

    // One full run: checks every cycle from E0 through the return to IDLE.
    task automatic do_run(input string tag, input bit tie_q, input bit noise, input bit load_with_start);
        int n;
        int hc;
        logic [4:0] exp;
        n = model_count;
        Start = 1'b1;
        Load = load_with_start;
        LoadData = 2'b11;
        @(negedge Clk);
        Start = 1'b0;
        Load = 1'b0;
        hc = 0;
        for (int c = 0; c <= n + 2; c++) begin
            if (c == 0)           exp = 5'b11000;
            else if (c <= n)      exp = {3'b010, model_buf[c-1]};
            else if (c == n + 1)  exp = 5'b01000;
            else                  exp = 5'b00100;
            check({tag, "_seq"}, 32'(outs()), 32'(exp));
            check({tag, "_high"}, 32'(HighCount), 32'(hc));
            q_in = tie_q ? 1'b1 : 1'($urandom);
            if (c >= 1 && c <= n + 1 && q_in && hc < HMAX) hc++;
            if (noise) begin
                Load = 1'($urandom);
                LoadData = 2'($urandom);
                Clear = 1'($urandom);
                Start = 1'($urandom);
            end
            @(negedge Clk);
        end
        Load = 1'b0;
        Clear = 1'b0;
        Start = 1'b0;
        q_in = 1'b0;
        model_high = hc;
        check_idle({tag, "_end"});
    endtask

    initial begin
        // Reset state
        #2;
        check_idle("reset_async");
        @(negedge Clk);
        Rst = 1'b0;
        check_idle("reset");

        // Two identical symbols
        load_sym(2'b11);
        load_sym(2'b11);
        do_run("pat11", 1'b0, 1'b0, 1'b0);

        // Single zero symbol
        clear_buf();
        load_sym(2'b00);
        do_run("pat00", 1'b0, 1'b0, 1'b0);

        // Overfill: ninth symbol dropped, Full after the eighth
        clear_buf();
        for (int i = 0; i < DEPTH + 1; i++) begin
            load_sym(2'($urandom));
            check("full_flag", 32'(Full), 32'(model_count == DEPTH));
        end
        do_run("full_run", 1'b0, 1'b0, 1'b0);

        // Start with an empty buffer is ignored
        clear_buf();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle("empty_start");
            @(negedge Clk);
        end

        // Load in the same cycle as an accepted Start is dropped
        load_sym(2'b01);
        load_sym(2'b10);
        do_run("start_load", 1'b0, 1'b0, 1'b1);
        do_run("after_drop", 1'b0, 1'b0, 1'b0);

        // Saturation with q_in tied high, and mid-run Load/Clear/Start ignored
        clear_buf();
        for (int i = 0; i < DEPTH; i++) load_sym(2'($urandom));
        do_run("saturate", 1'b1, 1'b1, 1'b0);
        check("sat_value", 32'(HighCount), HMAX);
        do_run("noise_kept", 1'b0, 1'b1, 1'b0);

        // Random patterns
        for (int r = 0; r < 6; r++) begin
            clear_buf();
            for (int i = 0; i < 1 + int'($urandom_range(DEPTH - 1)); i++) load_sym(2'($urandom));
            do_run("random", 1'b0, 1'($urandom), 1'b0);
        end

        // Asynchronous reset while symbol 2 is presented
        clear_buf();
        for (int i = 0; i < 5; i++) load_sym(2'($urandom));
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        q_in = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_pre_sym", 32'(outs()), 32'({3'b010, model_buf[2]}));
        #2;
        Rst = 1'b1;
        #1;
        model_count = 0;
        model_high = 0;
        q_in = 1'b0;
        check_idle("rst_mid");
        @(negedge Clk);
        Rst = 1'b0;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_idle("rst_start_ignored");
            @(negedge Clk);
        end
        load_sym(2'b10);
        load_sym(2'b01);
        load_sym(2'b11);
        do_run("reload", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
